// File: rtl/dds_pkg.sv
// Shared definitions for the DDS step controller: key indices, step increments,
// word width and FSM states.
package dds_pkg;

   localparam int STEP_W   = 32;
   localparam int NUM_KEYS = 6;

   typedef logic [2:0] key_idx_t;

   localparam key_idx_t KEY_COARSE_ADD = 3'd0;
   localparam key_idx_t KEY_COARSE_SUB = 3'd1;
   localparam key_idx_t KEY_MICRO_ADD  = 3'd2;
   localparam key_idx_t KEY_MICRO_SUB  = 3'd3;
   localparam key_idx_t KEY_NANO_ADD   = 3'd4;
   localparam key_idx_t KEY_NANO_SUB   = 3'd5;

   localparam logic [STEP_W-1:0] INC_COARSE = 32'd2147483;
   localparam logic [STEP_W-1:0] INC_MICRO  = 32'd214748;
   localparam logic [STEP_W-1:0] INC_NANO   = 32'd214;

   typedef enum logic [1:0] {IDLE, PUBLISH, HOLD} state_t;

   // Odd key indices subtract, even ones add; the pair selects the magnitude.
   function automatic logic [STEP_W-1:0] key_increment(input key_idx_t idx);
      case (idx)
         KEY_COARSE_ADD, KEY_COARSE_SUB: key_increment = INC_COARSE;
         KEY_MICRO_ADD,  KEY_MICRO_SUB:  key_increment = INC_MICRO;
         KEY_NANO_ADD,   KEY_NANO_SUB:   key_increment = INC_NANO;
         default:                        key_increment = '0;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and counter debouncer for one active-low key; emits the
// debounced pressed level and a one-cycle press pulse on each accepted 1->0 change.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n_i,
   output logic pressed_o,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q, sync_q;
   logic             state_q, state_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle where the synced level agrees with the accepted state restarts the count.
   always_comb begin
      cnt_d   = '0;
      state_d = state_q;
      press_d = 1'b0;
      if (sync_q != state_q) begin
         if (cnt_q == CNT_LAST) begin
            state_d = sync_q;
            press_d = ~sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         state_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= key_n_i;
         sync_q  <= meta_q;
         state_q <= state_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pressed_o = ~state_q;
   assign press_o   = press_q;

endmodule

// File: rtl/dds_step_controller.sv
// Front-panel tuning-word adjuster: debounced keys, priority arbitration, saturating
// step arithmetic with auto-repeat, and a valid/ready publish to the phase accumulator.
module dds_step_controller
   import dds_pkg::*;
#(
   parameter int unsigned       DEBOUNCE_CYCLES = 500000,
   parameter int unsigned       REPEAT_DELAY    = 25000000,
   parameter int unsigned       REPEAT_PERIOD   = 5000000,
   parameter logic [STEP_W-1:0] STEP_INIT       = 32'd2147483,
   parameter logic [STEP_W-1:0] STEP_MIN        = 32'd214,
   parameter logic [STEP_W-1:0] STEP_MAX        = 32'd4294967081
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        key_n,
   output logic [STEP_W-1:0] step,
   output logic              step_valid,
   input  logic              step_ready,
   output logic              busy
);

   logic [NUM_KEYS-1:0] pressed, press;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk      (clk),
         .reset    (reset),
         .key_n_i  (key_n[i]),
         .pressed_o(pressed[i]),
         .press_o  (press[i])
      );
   end

   // Carry/borrow kept in bit 32 so the clamp sees the true result, never a wrapped one.
   function automatic logic [STEP_W-1:0] sat_apply(input logic [STEP_W-1:0] cur,
                                                   input key_idx_t          idx);
      logic [STEP_W:0] wide;
      if (idx[0]) wide = {1'b0, cur} - {1'b0, key_increment(idx)};
      else        wide = {1'b0, cur} + {1'b0, key_increment(idx)};
      if (idx[0] && wide[STEP_W])     return STEP_MIN;
      if (wide > {1'b0, STEP_MAX})    return STEP_MAX;
      if (wide < {1'b0, STEP_MIN})    return STEP_MIN;
      return wide[STEP_W-1:0];
   endfunction

   state_t            state_q;
   key_idx_t          active_q;
   logic [STEP_W-1:0] step_q, step_d;
   logic              valid_q, busy_q, repeat_mode_q;
   logic [31:0]       rep_cnt_q, rep_cnt_inc, rep_last;
   logic              press_any;
   key_idx_t          win_idx, apply_idx;

   always_comb begin
      press_any = |press;
      win_idx   = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press[i]) win_idx = key_idx_t'(i);
      end
   end

   assign apply_idx   = (state_q == IDLE) ? win_idx : active_q;
   assign step_d      = sat_apply(step_q, apply_idx);
   assign rep_cnt_inc = (&rep_cnt_q) ? rep_cnt_q : rep_cnt_q + 32'd1;
   assign rep_last    = repeat_mode_q ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1);

   // The repeat counter runs from each apply, so a long PUBLISH stall counts towards the next repeat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         active_q      <= '0;
         step_q        <= STEP_INIT;
         valid_q       <= 1'b0;
         busy_q        <= 1'b0;
         rep_cnt_q     <= '0;
         repeat_mode_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (press_any) begin
                  active_q      <= win_idx;
                  step_q        <= step_d;
                  valid_q       <= 1'b1;
                  busy_q        <= 1'b1;
                  rep_cnt_q     <= '0;
                  repeat_mode_q <= 1'b0;
                  state_q       <= PUBLISH;
               end
            end
            PUBLISH: begin
               rep_cnt_q <= rep_cnt_inc;
               if (step_ready) begin
                  valid_q <= 1'b0;
                  if (pressed[active_q]) begin
                     state_q <= HOLD;
                  end else begin
                     state_q       <= IDLE;
                     busy_q        <= 1'b0;
                     rep_cnt_q     <= '0;
                     repeat_mode_q <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (!pressed[active_q]) begin
                  state_q       <= IDLE;
                  busy_q        <= 1'b0;
                  rep_cnt_q     <= '0;
                  repeat_mode_q <= 1'b0;
               end else if (rep_cnt_q >= rep_last) begin
                  step_q        <= step_d;
                  valid_q       <= 1'b1;
                  rep_cnt_q     <= '0;
                  repeat_mode_q <= 1'b1;
                  state_q       <= PUBLISH;
               end else begin
                  rep_cnt_q <= rep_cnt_inc;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign step       = step_q;
   assign step_valid = valid_q;
   assign busy       = busy_q;

endmodule

// File: doc/dds_step_controller.md
Name: dds_step_controller

Overview:
- Synchronous replacement for the DDS tuning-word adjuster.
- Takes six raw active-low front-panel keys and synchronises and debounces them.
- Arbitrates simultaneous presses; applies saturating coarse/micro/nano add/sub to the 32-bit phase step, with auto-repeat while a key is held.
- Publishes each new step to the phase accumulator through a valid/ready handshake. Sits between the key pins and the accumulator.

Parameters:
DEBOUNCE_CYCLES, 500000, stable cycles required before a key state is accepted (10 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles a key must stay held after its first apply before auto-repeat starts
REPEAT_PERIOD, 5000000, cycles between auto-repeat applies
STEP_INIT, 2147483, step value after reset
STEP_MIN, 214, lower saturation bound
STEP_MAX, 4294967081, upper saturation bound

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_n  input  6  raw keys, active-low, asynchronous; bit0 coarse+, bit1 coarse-, bit2 micro+, bit3 micro-, bit4 nano+, bit5 nano-
step  output  32  current tuning word
step_valid  output  1  new step offered to accumulator
step_ready  input  1  accumulator accepts step
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async assert, sync release):
  - step=STEP_INIT, step_valid=0, busy=0, FSM=IDLE.
  - All sync flops at 1 (released); debounce counters 0; repeat counter 0.
- Input path:
  - 2-flop synchroniser per key.
  - Debounced state changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synced value; any glitch restarts the count.
  - A press event is a debounced 1->0 transition, one cycle wide.
- Increments: bits0/1 = 2147483, bits2/3 = 214748, bits4/5 = 214.
- Arithmetic: 33-bit sum/difference, then clamped to [STEP_MIN, STEP_MAX]. Never wraps.
- Arbitration: if several press events fire in the same cycle, the lowest key index wins and the rest are discarded. Press events arriving while the FSM is not IDLE are discarded.
- FSM:
  - IDLE: on a press event, latch the key index as active_key, apply its increment to step, go to PUBLISH. step and step_valid=1 update on the same edge, i.e. 1 cycle after the debounced press event.
  - PUBLISH: hold step_valid=1 and step stable until step_ready=1. On that handshake cycle, drop step_valid next edge. Then go to HOLD if active_key is still debounced-pressed, else IDLE.
  - HOLD: count cycles while active_key is held.
    - First repeat apply when the counter reaches REPEAT_DELAY since entry from the first apply.
    - Subsequent repeats every REPEAT_PERIOD.
    - Each apply updates step, asserts step_valid and goes to PUBLISH; the counter mode persists, so later HOLD entries use REPEAT_PERIOD.
    - Release of active_key -> IDLE; counter cleared.
- Saturation does not suppress publishing: a clamped result equal to the old step is still offered with step_valid.
- Once a step_valid is asserted, no further apply occurs until the handshake completes. The step_ready=0 stall is unbounded.
- step_ready while step_valid=0 is ignored.
- Reset mid-handshake: step_valid drops immediately (async) and step returns to STEP_INIT. No completion is owed to the accumulator.

Decomposition:
- Shared package dds_pkg:
  - key index constants (KEY_COARSE_ADD..KEY_NANO_SUB)
  - increment constants (INC_COARSE=2147483, INC_MICRO=214748, INC_NANO=214)
  - STEP_W=32
  - FSM state enum {IDLE, PUBLISH, HOLD}
- One sub-module: key_debounce (synchroniser + counter + press-event output, parameter DEBOUNCE_CYCLES), instantiated six times.
- Arbitration, arithmetic and FSM stay in the top level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Single coarse+: after reset, hold key_n[0]=0 for 10 cycles with step_ready=1 -> step goes 2147483->4294966, one step_valid pulse, then IDLE after release.
- Bounce rejection: key_n[2] low for 3 cycles, high 2, low 3, then high -> step unchanged, step_valid never asserted.
- Simultaneous press: key_n[1] and key_n[4] fall in the same cycle -> only coarse- applied; step saturates from 2147483 to STEP_MIN=214; step_valid asserted even though the result was clamped.
- Saturation high: force step near max via repeated coarse+ -> step never exceeds 4294967081 and never wraps to a small value.
- Auto-repeat: hold nano+ 60 cycles past debounce, step_ready=1 -> applies at press, +20, +28, +36, ...; step increments by 214 each time; stops on release.
- Stall and reset: step_ready=0 after micro+ -> step_valid and step held 50 cycles; a second key press is ignored. Then assert reset -> step_valid=0 and step=2147483 within the same cycle.
